regfile_32x8_2r1w: RTL and testbench



---
 rtl/regfile_32x8_2r1w.sv | 114 +++++++++++
 tb/tb_regfile_32x8_2r1w.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_32x8_2r1w.sv
// 32 x 8 general-purpose register file: one synchronous write port, two
// combinational read ports built from one-hot decoders and an AND-OR read tree.

module regfile_dec #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DEPTH-1:0]  onehot_o
);

   always_comb begin
      onehot_o         = '0;
      onehot_o[addr_i] = 1'b1;
   end

endmodule

module regfile_cell #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (we_i) begin
         data_d = d_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

module regfile_32x8_2r1w #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [ADDR_W-1:0] write_add,
   input  logic [DATA_W-1:0] write_inp,
   input  logic [ADDR_W-1:0] read_add_1,
   input  logic [ADDR_W-1:0] read_add_2,
   output logic [DATA_W-1:0] read_out_1,
   output logic [DATA_W-1:0] read_out_2
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0]  dec_wr;
   logic [DEPTH-1:0]  dec_rd1;
   logic [DEPTH-1:0]  dec_rd2;
   logic [DATA_W-1:0] entry_q [DEPTH];
   logic [DATA_W-1:0] rd1_d;
   logic [DATA_W-1:0] rd2_d;

   regfile_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_wr (
      .addr_i   (write_add),
      .onehot_o (dec_wr)
   );

   regfile_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_rd1 (
      .addr_i   (read_add_1),
      .onehot_o (dec_rd1)
   );

   regfile_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_rd2 (
      .addr_i   (read_add_2),
      .onehot_o (dec_rd2)
   );

   // Each entry sees only its own decoded write bit, so at most one cell loads per edge.
   for (genvar k = 0; k < DEPTH; k++) begin : g_cell
      regfile_cell #(.DATA_W(DATA_W)) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .we_i  (mode & dec_wr[k]),
         .d_i   (write_inp),
         .q_o   (entry_q[k])
      );
   end

   // Read data comes straight from the cells: a same-address write is seen only after the edge.
   always_comb begin
      rd1_d = '0;
      rd2_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         rd1_d = rd1_d | (entry_q[k] & {DATA_W{dec_rd1[k]}});
         rd2_d = rd2_d | (entry_q[k] & {DATA_W{dec_rd2[k]}});
      end
   end

   assign read_out_1 = rd1_d;
   assign read_out_2 = rd2_d;

endmodule

// File: tb/tb_regfile_32x8_2r1w.sv
// Directed bench for regfile_32x8_2r1w; a driver queues expected read data and a
// negedge monitor compares whenever the driver raises chk_req.

module tb_regfile_32x8_2r1w;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mode;
   logic [4:0] write_add;
   logic [7:0] write_inp;
   logic [4:0] read_add_1;
   logic [4:0] read_add_2;
   logic [7:0] read_out_1;
   logic [7:0] read_out_2;

   // chk_req acts as "valid": high from posedge+1 to negedge+1, one queue entry per pulse.
   logic       chk_req = 1'b0;
   logic [15:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;

   regfile_32x8_2r1w dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .write_add  (write_add),
      .write_inp  (write_inp),
      .read_add_1 (read_add_1),
      .read_add_2 (read_add_2),
      .read_out_1 (read_out_1),
      .read_out_2 (read_out_2)
   );

   // clock / reset
   always #5 clk = ~clk;

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [15:0] e;
      string       nm;
      if (chk_req) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %0t no_expected: monitor saw a request with an empty queue", $time);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (read_out_1 !== e[15:8]) begin
               errors++;
               $display("FAIL %0t %s port1 addr=%0d got=%h exp=%h", $time, nm, read_add_1,
                        read_out_1, e[15:8]);
            end
            checks++;
            if (read_out_2 !== e[7:0]) begin
               errors++;
               $display("FAIL %0t %s port2 addr=%0d got=%h exp=%h", $time, nm, read_add_2,
                        read_out_2, e[7:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      mode      = 1'b1;
      write_add = a;
      write_inp = d;
      tick();
      mode      = 1'b0;
   endtask

   // Samples at the coming negedge (before the next write edge), then steps past that edge.
   task automatic check(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [7:0] e1, input logic [7:0] e2);
      read_add_1 = a1;
      read_add_2 = a2;
      exp_q.push_back({e1, e2});
      name_q.push_back(nm);
      chk_req = 1'b1;
      @(negedge clk);
      #1;
      chk_req = 1'b0;
      tick();
   endtask

   task automatic report();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
   endtask

   initial begin
      rst_n      = 1'b0;
      mode       = 1'b0;
      write_add  = '0;
      write_inp  = '0;
      read_add_1 = '0;
      read_add_2 = '0;
      tick();
      check("rst_init", 5'd0, 5'd31, 8'h00, 8'h00);
      rst_n = 1'b1;
      check("post_rst", 5'd3, 5'd17, 8'h00, 8'h00);

      // basic write / read
      wr(5'd7, 8'h23);
      wr(5'd11, 8'h39);
      check("basic", 5'd11, 5'd7, 8'h39, 8'h23);
      check("same_addr", 5'd7, 5'd7, 8'h23, 8'h23);

      // write disable
      mode      = 1'b0;
      write_add = 5'd6;
      write_inp = 8'hCC;
      repeat (3) tick();
      check("wr_dis", 5'd6, 5'd6, 8'h00, 8'h00);
      wr(5'd6, 8'hCC);
      check("wr_en", 5'd6, 5'd7, 8'hCC, 8'h23);

      // read during write, same address
      wr(5'd5, 8'h11);
      mode      = 1'b1;
      write_add = 5'd5;
      write_inp = 8'hA5;
      check("rdw_before", 5'd5, 5'd4, 8'h11, 8'h00);
      mode = 1'b0;
      check("rdw_after", 5'd5, 5'd4, 8'hA5, 8'h00);

      // address walk
      for (int k = 0; k < 32; k++) begin
         wr(5'(k), 8'((k * 7 + 3) % 256));
      end
      for (int k = 0; k < 32; k++) begin
         check("walk", 5'(k), 5'(31 - k), 8'((k * 7 + 3) % 256), 8'(((31 - k) * 7 + 3) % 256));
      end
      check("alias_28_29", 5'd28, 5'd29, 8'hC7, 8'hCE);
      check("entry_11", 5'd11, 5'd11, 8'h50, 8'h50);

      // async reset between edges while a write is pending
      mode      = 1'b1;
      write_add = 5'd9;
      write_inp = 8'h77;
      #1;
      rst_n = 1'b0;
      check("rst_imm", 5'd9, 5'd28, 8'h00, 8'h00);
      check("rst_nowr", 5'd9, 5'd9, 8'h00, 8'h00);
      mode = 1'b0;
      for (int k = 0; k < 32; k++) begin
         check("rst_all", 5'(k), 5'(31 - k), 8'h00, 8'h00);
      end
      rst_n = 1'b1;
      check("rst_rel", 5'd9, 5'd11, 8'h00, 8'h00);
      wr(5'd9, 8'h77);
      check("post_rst_wr", 5'd9, 5'd28, 8'h77, 8'h00);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end
      report();
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: time limit reached before the directed sequence ended");
      report();
      $finish;
   end

endmodule
